dip_switch_input: RTL

Input-conditioning stage between the board's 8-bit DIP switch / push-button pins and the 8-bit value register that drives the hex display driver. It synchronises the raw pins into the clock domain, debounces the switch bus and the button, emits single-cycle press/release strobes, and latches the debounced switch value on each button press. Its `latched_val` output connects directly to the display driver's `hex_val` input, replacing the undebounced level-sensitive load in the top level.

---
 rtl/dip_switch_input_if.sv | 20 ++
 rtl/dip_switch_input.sv | 86 ++++++++
 2 files changed

// File: rtl/dip_switch_input_if.sv
// rtl/dip_switch_input_if.sv - raw switch/button pins and conditioned outputs bundle
interface dip_switch_input_if;
  logic [7:0] sw_in;
  logic       btn_in;
  logic [7:0] sw_val;
  logic       btn_level;
  logic       btn_press;
  logic       btn_release;
  logic [7:0] latched_val;

  modport master (
    output sw_in, btn_in,
    input  sw_val, btn_level, btn_press, btn_release, latched_val
  );

  modport slave (
    input  sw_in, btn_in,
    output sw_val, btn_level, btn_press, btn_release, latched_val
  );
endinterface

// File: rtl/dip_switch_input.sv
// rtl/dip_switch_input.sv - synchronise, debounce and latch DIP switch / button inputs
module dip_switch_input #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                clk,
  input  logic                rst,
  dip_switch_input_if.slave   io
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       s1_sw, s2_sw, cand_sw, stable_sw;
  logic [CNT_W-1:0] cnt_sw;
  logic             s1_btn, s2_btn, cand_btn, stable_btn;
  logic [CNT_W-1:0] cnt_btn;
  logic             press_q, release_q;
  logic [7:0]       latched_q;
  logic             sw_accept, btn_accept;

  // The whole bus shares one counter so a multi-bit change lands atomically.
  always_comb begin
    sw_accept  = 1'b0;
    btn_accept = 1'b0;
    if ((s2_sw != stable_sw) && (s2_sw == cand_sw) && (cnt_sw == CNT_MAX))
      sw_accept = 1'b1;
    if ((s2_btn != stable_btn) && (s2_btn == cand_btn) && (cnt_btn == CNT_MAX))
      btn_accept = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sw      <= '0;
      s2_sw      <= '0;
      cand_sw    <= '0;
      cnt_sw     <= '0;
      stable_sw  <= '0;
      s1_btn     <= 1'b0;
      s2_btn     <= 1'b0;
      cand_btn   <= 1'b0;
      cnt_btn    <= '0;
      stable_btn <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      latched_q  <= '0;
    end else begin
      s1_sw    <= io.sw_in;
      s2_sw    <= s1_sw;
      cand_sw  <= s2_sw;
      s1_btn   <= io.btn_in;
      s2_btn   <= s1_btn;
      cand_btn <= s2_btn;

      if ((s2_sw == stable_sw) || (s2_sw != cand_sw)) begin
        cnt_sw <= '0;
      end else if (sw_accept) begin
        stable_sw <= s2_sw;
        cnt_sw    <= '0;
      end else begin
        cnt_sw <= cnt_sw + 1'b1;
      end

      if ((s2_btn == stable_btn) || (s2_btn != cand_btn)) begin
        cnt_btn <= '0;
      end else if (btn_accept) begin
        stable_btn <= s2_btn;
        cnt_btn    <= '0;
      end else begin
        cnt_btn <= cnt_btn + 1'b1;
      end

      press_q   <= btn_accept & s2_btn;
      release_q <= btn_accept & ~s2_btn;
      // stable_sw is still the pre-edge value here, so a simultaneous bus change is not captured.
      if (btn_accept && s2_btn)
        latched_q <= stable_sw;
    end
  end

  assign io.sw_val      = stable_sw;
  assign io.btn_level   = stable_btn;
  assign io.btn_press   = press_q;
  assign io.btn_release = release_q;
  assign io.latched_val = latched_q;

endmodule
